// File: rtl/issue_ctrl_pkg.sv
// Shared types and defaults for the dual-issue scheduler and its scoreboard.
package issue_ctrl_pkg;

  localparam int LOAD_LAT_DEF = 2;
  localparam int MD_LAT_DEF   = 4;

  typedef struct packed {
    logic [4:0] rj;
    logic [4:0] rk;
    logic [4:0] rd;
    logic       use_rj;
    logic       use_rk;
    logic       rf_we;
    logic       is_mem;
    logic       is_md;
    logic       is_br;
    logic       is_load;
  } issue_slot_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decoded-pair / back-end signals seen by the issue controller.
// Handshake: this is a per-cycle consume count, not valid/ready; the pair register
// drops issue_num instructions at the next edge, and nothing is consumed while be_stall or flush is high.
interface issue_ctrl_if;
  logic [1:0]  valid;
  logic [4:0]  a_rj, a_rk, a_rd;
  logic        a_use_rj, a_use_rk, a_rf_we;
  logic        a_is_mem, a_is_md, a_is_br, a_is_load;
  logic [4:0]  b_rj, b_rk, b_rd;
  logic        b_use_rj, b_use_rk, b_rf_we;
  logic        b_is_mem, b_is_md, b_is_br, b_is_load;
  logic        be_stall;
  logic        flush;
  logic [1:0]  issue_num;
  logic        issue_a, issue_b;
  logic [31:0] sb_busy;

  modport master (
    output valid,
    output a_rj, a_rk, a_rd, a_use_rj, a_use_rk, a_rf_we,
    output a_is_mem, a_is_md, a_is_br, a_is_load,
    output b_rj, b_rk, b_rd, b_use_rj, b_use_rk, b_rf_we,
    output b_is_mem, b_is_md, b_is_br, b_is_load,
    output be_stall, flush,
    input  issue_num, issue_a, issue_b, sb_busy
  );

  modport slave (
    input  valid,
    input  a_rj, a_rk, a_rd, a_use_rj, a_use_rk, a_rf_we,
    input  a_is_mem, a_is_md, a_is_br, a_is_load,
    input  b_rj, b_rk, b_rd, b_use_rj, b_use_rk, b_rf_we,
    input  b_is_mem, b_is_md, b_is_br, b_is_load,
    input  be_stall, flush,
    output issue_num, issue_a, issue_b, sb_busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Per-register countdown of long-latency producers in flight, with four
// source-busy lookup ports. Register 0 never goes busy.
module issue_scoreboard (
  input  logic            clk,
  input  logic            rst,
  input  logic            be_stall,
  input  logic [3:0][4:0] rd_reg,
  input  logic [3:0]      rd_use,
  input  logic [1:0]      wr_en,
  input  logic [1:0][4:0] wr_rd,
  input  logic [1:0][1:0] wr_val,
  output logic [3:0]      src_busy,
  output logic [31:0]     sb_busy
);

  logic [31:0][1:0] cnt;

  // Slot a has priority only nominally; the pair never writes the same rd.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (rst || r == 0) begin
        cnt[r] <= 2'd0;
      end else if (!be_stall) begin
        if (wr_en[1] && wr_rd[1] == 5'(r)) begin
          cnt[r] <= wr_val[1];
        end else if (wr_en[0] && wr_rd[0] == 5'(r)) begin
          cnt[r] <= wr_val[0];
        end else if (cnt[r] != 2'd0) begin
          cnt[r] <= cnt[r] - 2'd1;
        end
      end
    end
  end

  always_comb begin
    sb_busy = '0;
    for (int r = 0; r < 32; r++) begin
      sb_busy[r] = (cnt[r] != 2'd0);
    end
  end

  always_comb begin
    src_busy = '0;
    for (int p = 0; p < 4; p++) begin
      src_busy[p] = rd_use[p] && (rd_reg[p] != 5'd0) && sb_busy[rd_reg[p]];
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order dual-issue decision: slot a gates on scoreboard hazards, slot b
// additionally on intra-pair RAW/WAW, structural limits and branches.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MD_LAT   = MD_LAT_DEF
) (
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);

  localparam logic [1:0] LOAD_INIT = 2'(LOAD_LAT - 1);
  localparam logic [1:0] MD_INIT   = 2'(MD_LAT - 1);

  issue_slot_t slot_a, slot_b;
  logic [3:0]  src_busy;
  logic [31:0] sb_busy;
  logic        issue_a, issue_b;
  logic        pair_raw, pair_waw, pair_mem, pair_md;
  logic [1:0]  wr_en;
  logic [1:0][4:0] wr_rd;
  logic [1:0][1:0] wr_val;
  logic        unused_b_br;

  assign slot_a = '{rj: bus.a_rj, rk: bus.a_rk, rd: bus.a_rd,
                    use_rj: bus.a_use_rj, use_rk: bus.a_use_rk, rf_we: bus.a_rf_we,
                    is_mem: bus.a_is_mem, is_md: bus.a_is_md, is_br: bus.a_is_br,
                    is_load: bus.a_is_load};
  assign slot_b = '{rj: bus.b_rj, rk: bus.b_rk, rd: bus.b_rd,
                    use_rj: bus.b_use_rj, use_rk: bus.b_use_rk, rf_we: bus.b_rf_we,
                    is_mem: bus.b_is_mem, is_md: bus.b_is_md, is_br: bus.b_is_br,
                    is_load: bus.b_is_load};

  // A branch in slot b has no pairing restriction of its own.
  assign unused_b_br = slot_b.is_br;

  always_comb begin
    pair_raw = slot_a.rf_we && (slot_a.rd != 5'd0) &&
               ((slot_b.use_rj && slot_b.rj == slot_a.rd) ||
                (slot_b.use_rk && slot_b.rk == slot_a.rd));
    pair_waw = slot_a.rf_we && slot_b.rf_we && (slot_a.rd == slot_b.rd) &&
               (slot_a.rd != 5'd0);
    pair_mem = slot_a.is_mem && slot_b.is_mem;
    pair_md  = slot_a.is_md && slot_b.is_md;

    issue_a = bus.valid[1] && !src_busy[3] && !src_busy[2] &&
              !bus.be_stall && !bus.flush && !rst;
    issue_b = issue_a && bus.valid[0] && !src_busy[1] && !src_busy[0] &&
              !pair_raw && !pair_waw && !pair_mem && !pair_md && !slot_a.is_br;
  end

  // Scoreboard write ports: index 1 = slot a, index 0 = slot b.
  always_comb begin
    wr_en[1]  = issue_a && (slot_a.is_load || slot_a.is_md) && slot_a.rf_we &&
                (slot_a.rd != 5'd0);
    wr_en[0]  = issue_b && (slot_b.is_load || slot_b.is_md) && slot_b.rf_we &&
                (slot_b.rd != 5'd0);
    wr_rd[1]  = slot_a.rd;
    wr_rd[0]  = slot_b.rd;
    wr_val[1] = slot_a.is_load ? LOAD_INIT : MD_INIT;
    wr_val[0] = slot_b.is_load ? LOAD_INIT : MD_INIT;
  end

  issue_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .be_stall (bus.be_stall),
    .rd_reg   ({slot_a.rj, slot_a.rk, slot_b.rj, slot_b.rk}),
    .rd_use   ({slot_a.use_rj, slot_a.use_rk, slot_b.use_rj, slot_b.use_rk}),
    .wr_en    (wr_en),
    .wr_rd    (wr_rd),
    .wr_val   (wr_val),
    .src_busy (src_busy),
    .sb_busy  (sb_busy)
  );

  assign bus.issue_a   = issue_a;
  assign bus.issue_b   = issue_b;
  assign bus.issue_num = {1'b0, issue_a} + {1'b0, issue_b};
  assign bus.sb_busy   = sb_busy;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   row   = 0;

  logic [1:0]  exp_q[$];
  logic [32:0] sb_q[$];
  int          id_q[$];

  issue_ctrl_if bus ();

  issue_ctrl #(.LOAD_LAT(2), .MD_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic issue_slot_t mk(input logic [4:0] rd, rj, rk,
                                     input logic urj, urk, we, mem, md, br, ld);
    issue_slot_t s;
    s = '{rj: rj, rk: rk, rd: rd, use_rj: urj, use_rk: urk, rf_we: we,
          is_mem: mem, is_md: md, is_br: br, is_load: ld};
    return s;
  endfunction

  function automatic issue_slot_t alu(input logic [4:0] rd, rj, rk);
    return mk(rd, rj, rk, 1, 1, 1, 0, 0, 0, 0);
  endfunction
  function automatic issue_slot_t ldi(input logic [4:0] rd, rj);
    return mk(rd, rj, 5'd0, 1, 0, 1, 1, 0, 0, 1);
  endfunction
  function automatic issue_slot_t sti(input logic [4:0] rj, rk);
    return mk(5'd0, rj, rk, 1, 1, 0, 1, 0, 0, 0);
  endfunction
  function automatic issue_slot_t mdi(input logic [4:0] rd, rj, rk);
    return mk(rd, rj, rk, 1, 1, 1, 0, 1, 0, 0);
  endfunction
  function automatic issue_slot_t bri(input logic [4:0] rj, rk);
    return mk(5'd0, rj, rk, 1, 1, 0, 0, 0, 1, 0);
  endfunction

  localparam issue_slot_t NONE = '0;

  // One cycle of stimulus plus its expected response.
  task automatic step(input logic [1:0] v, input issue_slot_t a, input issue_slot_t b,
                      input logic stall, input logic fl, input logic r,
                      input logic [1:0] exp_num, input logic chk_sb,
                      input logic [31:0] exp_sb);
    @(posedge clk);
    #1;
    rst          = r;
    bus.valid    = v;
    bus.a_rj     = a.rj;     bus.a_rk     = a.rk;     bus.a_rd    = a.rd;
    bus.a_use_rj = a.use_rj; bus.a_use_rk = a.use_rk; bus.a_rf_we = a.rf_we;
    bus.a_is_mem = a.is_mem; bus.a_is_md  = a.is_md;  bus.a_is_br = a.is_br;
    bus.a_is_load = a.is_load;
    bus.b_rj     = b.rj;     bus.b_rk     = b.rk;     bus.b_rd    = b.rd;
    bus.b_use_rj = b.use_rj; bus.b_use_rk = b.use_rk; bus.b_rf_we = b.rf_we;
    bus.b_is_mem = b.is_mem; bus.b_is_md  = b.is_md;  bus.b_is_br = b.is_br;
    bus.b_is_load = b.is_load;
    bus.be_stall = stall;
    bus.flush    = fl;
    exp_q.push_back(exp_num);
    sb_q.push_back({chk_sb, exp_sb});
    id_q.push_back(row);
    row++;
  endtask

  // Monitor: the decision is combinational, so every driven cycle is an output.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [1:0]  e;
      logic [32:0] s;
      int          id;
      e  = exp_q.pop_front();
      s  = sb_q.pop_front();
      id = id_q.pop_front();
      tests++;
      if (bus.issue_num !== e || bus.issue_a !== (e != 2'd0) ||
          bus.issue_b !== (e == 2'd2)) begin
        fails++;
        $display("FAIL issue row %0d: got num=%0d a=%b b=%b, expected num=%0d",
                 id, bus.issue_num, bus.issue_a, bus.issue_b, e);
      end
      if (s[32]) begin
        tests++;
        if (bus.sb_busy !== s[31:0]) begin
          fails++;
          $display("FAIL sb_busy row %0d: got %h, expected %h", id, bus.sb_busy, s[31:0]);
        end
      end
    end
  end

  initial begin
    bus.valid = 2'b00;
    bus.be_stall = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    // 0: reset holds issue at 0
    step(2'b11, alu(4, 1, 2), alu(5, 6, 7), 0, 0, 1, 2'd0, 1, 32'h0);
    // 1: independent pair
    step(2'b11, alu(4, 1, 2), alu(5, 6, 7), 0, 0, 0, 2'd2, 1, 32'h0);
    // 2-3: intra-pair RAW, then the consumer moves to slot a
    step(2'b11, alu(4, 1, 2), alu(6, 4, 3), 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b11, alu(6, 4, 3), alu(10, 11, 12), 0, 0, 0, 2'd2, 1, 32'h0);
    // 4-6: load-use
    step(2'b11, ldi(8, 1), alu(9, 8, 2), 0, 0, 0, 2'd1, 1, 32'h0);
    step(2'b10, alu(9, 8, 2), NONE, 0, 0, 0, 2'd0, 1, 32'h100);
    step(2'b10, alu(9, 8, 2), NONE, 0, 0, 0, 2'd1, 1, 32'h0);
    // 7-8: consumer of r0 not blocked by a busy r8
    step(2'b10, ldi(8, 1), NONE, 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b10, alu(9, 0, 2), NONE, 0, 0, 0, 2'd1, 1, 32'h100);
    // 9-13: mul then use
    step(2'b10, mdi(9, 1, 2), NONE, 0, 0, 0, 2'd1, 1, 32'h0);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd1, 1, 32'h0);
    // 14-19: mul then use with be_stall at t+2
    step(2'b10, mdi(9, 1, 2), NONE, 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b11, alu(3, 9, 1), alu(5, 6, 7), 1, 0, 0, 2'd0, 1, 32'h200);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b10, alu(3, 9, 1), NONE, 0, 0, 0, 2'd1, 1, 32'h0);
    // 20-23: structural and branch limits
    step(2'b11, ldi(10, 1), sti(2, 3), 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b11, mdi(11, 1, 2), mdi(12, 3, 4), 0, 0, 0, 2'd1, 1, 32'h400);
    step(2'b11, bri(1, 2), alu(13, 14, 15), 0, 0, 0, 2'd1, 1, 32'h800);
    step(2'b11, alu(3, 1, 2), alu(3, 5, 6), 0, 0, 0, 2'd1, 1, 32'h800);
    // 24-25: flush blocks issue, counters keep draining
    step(2'b11, alu(4, 1, 2), alu(5, 6, 7), 0, 1, 0, 2'd0, 1, 32'h800);
    step(2'b00, NONE, NONE, 0, 0, 0, 2'd0, 1, 32'h0);
    // 26-31: flush with be_stall holds counters
    step(2'b10, mdi(9, 1, 2), NONE, 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b11, alu(4, 1, 2), alu(5, 6, 7), 1, 1, 0, 2'd0, 1, 32'h200);
    step(2'b00, NONE, NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b00, NONE, NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b00, NONE, NONE, 0, 0, 0, 2'd0, 1, 32'h200);
    step(2'b00, NONE, NONE, 0, 0, 0, 2'd0, 1, 32'h0);
    // 32-35: reset mid-operation clears counters
    step(2'b10, mdi(9, 1, 2), NONE, 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b10, ldi(8, 1), NONE, 0, 0, 0, 2'd1, 1, 32'h200);
    step(2'b11, alu(4, 1, 2), alu(5, 6, 7), 0, 0, 1, 2'd0, 1, 32'h300);
    step(2'b00, NONE, NONE, 0, 0, 0, 2'd0, 1, 32'h0);
    // 36-37: load to r0 never marks a register busy
    step(2'b10, ldi(0, 1), NONE, 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b10, alu(1, 0, 0), NONE, 0, 0, 0, 2'd1, 1, 32'h0);
    // 38: slot b alone never issues
    step(2'b01, NONE, alu(5, 6, 7), 0, 0, 0, 2'd0, 1, 32'h0);
    // 39-41: busy source in slot b only
    step(2'b10, ldi(8, 1), NONE, 0, 0, 0, 2'd1, 0, 32'h0);
    step(2'b11, alu(4, 1, 2), alu(5, 8, 1), 0, 0, 0, 2'd1, 1, 32'h100);
    step(2'b00, NONE, NONE, 0, 0, 0, 2'd0, 1, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
